ptosda_arbiter: RTL and testbench
=================================

// Module: ptosda_arbiter
// PURPOSE
//   Shares one ptosda-style 4-bit parallel-to-serial SDA transmitter between N requesters.
//   Round-robin arbiter plus sequencer:
//   - picks a requester and presents its nibble;
//   - pulses the serializer load strobe;
//   - tracks the serializer busy flag until the frame is finished;
//   - returns a one-cycle done pulse to the winning requester.
//   Sits between the nibble sources and the serializer, in the sclk domain.
// PARAMETERS
//   N        4    number of requesters (2..8)
//   TIMEOUT  64   watchdog limit in sclk cycles for one transfer (only with ARB_TIMEOUT_EN)
//   TW       8    watchdog counter width; TIMEOUT must be < 2**TW
// PORTS
//   sclk      in   1     system clock; all logic on posedge
//   rst       in   1     asynchronous reset, active-high
//   req       in   N     request per requester; level, sampled only in IDLE
//   req_data  in   4*N   nibbles; requester i at [4*i+3:4*i]
//   gnt       out  N     one-hot grant; held for the whole transfer
//   done      out  N     one-cycle pulse to the winner when its frame completes
//   ser_data  out  4     nibble to serializer; stable from LOAD until return to IDLE
//   ser_load  out  1     one-cycle load strobe to serializer
//   ser_busy  in   1     serializer busy (start..stop of frame)
//   err       out  1     one-cycle watchdog-abort pulse; constant 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//   Reset (async, any state):
//   - gnt, done, ser_data, ser_load, err = 0; state = IDLE.
//   - RR pointer = N-1, so requester 0 wins first.
//   IDLE:
//   - If |req: winner = first set req searching from pointer+1 upward, modulo N.
//   - Register gnt = onehot(winner) and ser_data = req_data[winner]; go LOAD.
//   - Else stay in IDLE.
//   LOAD: ser_load = 1 for exactly this cycle; go WAIT_BUSY.
//   WAIT_BUSY: on ser_busy = 1, go WAIT_DONE.
//   WAIT_DONE, on ser_busy = 0:
//   - done[winner] = 1 for one cycle; gnt = 0; pointer = winner; go IDLE.
//   Latency:
//   - req sampled high at edge k -> gnt and ser_data valid after edge k;
//     ser_load high after edge k+1.
//   - Back-to-back: done at cycle t -> next gnt at t+1; one IDLE cycle per transfer.
//   Requester-side rules:
//   - req deasserted mid-transfer is ignored; the transfer runs to completion.
//   - req_data changes after grant are ignored; the nibble is captured in IDLE only.
//   - A requester still requesting after its done is re-eligible.
//     It loses to any other pending requester (RR fairness).
//   Serializer-side rules:
//   - ser_busy already 1 while in LOAD: WAIT_BUSY exits on the next cycle, no extra wait.
//   - gnt is always one-hot or zero; done is never set for a non-granted index.
//   Wrap-around: pointer = N-1 searches 0,1,..,N-1.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//   - Counter clears on entering LOAD and increments in WAIT_BUSY and WAIT_DONE.
//   - On reaching TIMEOUT: err = 1 for one cycle, gnt = 0, no done pulse,
//     pointer = winner, go IDLE.
//   - ser_busy rising on the same cycle the count hits TIMEOUT: the timeout wins.
//   ARB_TIMEOUT_EN undefined:
//   - No counter; err tied 0; the sequencer waits indefinitely on ser_busy.
// TESTING
//   1 rst high mid WAIT_DONE ->
//     all outputs 0 immediately; after release, req=4'b1111 grants 4'b0001 first.
//   2 N=4, req=4'b0100, data2=4'hA, model busy 3 cycles after load for 10 cycles ->
//     gnt=4'b0100, ser_data=4'hA, one ser_load pulse, done=4'b0100 once.
//   3 req=4'b1111 held, 8 transfers -> grant order 0,1,2,3,0,1,2,3; no gaps > 1 IDLE cycle.
//   4 req=4'b0010 then dropped to 0 right after grant -> transfer completes; done[1] pulses.
//   5 busy asserted during LOAD ->
//     WAIT_BUSY lasts one cycle; done when busy falls; ser_data stays stable throughout.
//   6 ARB_TIMEOUT_EN, TIMEOUT=64, busy stuck 1 ->
//     err pulses 64 cycles after LOAD; no done; next requester granted; undefined build: err stays 0.

Source files
------------

// File: rtl/ptosda_arbiter.sv
// Round-robin arbiter and load/busy sequencer sharing one ptosda 4-bit serializer among N requesters.
// Optional watchdog abort is compiled in with `define ARB_TIMEOUT_EN.
module ptosda_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64,
    parameter int TW      = 8
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [4*N-1:0]   req_data,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     done,
    output logic [3:0]       ser_data,
    output logic             ser_load,
    input  logic             ser_busy,
    output logic             err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state_r;
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] win_r;
    logic [N-1:0]  gnt_r;
    logic [N-1:0]  done_r;
    logic [3:0]    ser_data_r;
    logic          ser_load_r;

    logic [PW-1:0] pick_s;
    logic [PW-1:0] cand_s;
    logic          found_s;
    logic          timeout_s;
    logic [3:0]    nib_s [N];

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Split the flat request bus into per-requester nibbles
    always_comb begin
        for (int i = 0; i < N; i++) begin
            nib_s[i] = req_data[4*i +: 4];
        end
    end

    // Round-robin search starting just after the last winner, wrapping modulo N
    always_comb begin
        pick_s  = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 1; i <= N; i++) begin
            cand_s = PW'((int'(ptr_r) + i) % N);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [TW-1:0] cnt_r;
    logic          err_r;

    assign timeout_s = ((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) &&
                       (cnt_r == TW'(TIMEOUT - 1));

    // Watchdog: counts cycles spent waiting on the serializer, flags one-cycle abort
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            err_r <= 1'b0;
        end else begin
            err_r <= timeout_s;
            if (state_r == LOAD) begin
                cnt_r <= '0;
            end else if ((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) begin
                cnt_r <= cnt_r + 1'b1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign err = err_r;
`else
    logic unused_cfg_s;

    assign timeout_s    = 1'b0;
    assign unused_cfg_s = (TIMEOUT < (1 << TW)) ? 1'b0 : 1'b1;
    assign err          = 1'b0;
`endif

    // Sequencer: grant and capture in IDLE, strobe load, follow busy to completion
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= PW'(N - 1);
            win_r      <= '0;
            gnt_r      <= '0;
            done_r     <= '0;
            ser_data_r <= 4'h0;
            ser_load_r <= 1'b0;
        end else begin
            done_r     <= '0;
            ser_load_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        win_r      <= pick_s;
                        gnt_r      <= onehot(pick_s);
                        ser_data_r <= nib_s[pick_s];
                        state_r    <= LOAD;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                LOAD: begin
                    ser_load_r <= 1'b1;
                    state_r    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Abort takes priority over a busy edge arriving on the same cycle
                    if (timeout_s) begin
                        gnt_r   <= '0;
                        ptr_r   <= win_r;
                        state_r <= IDLE;
                    end else if (ser_busy) begin
                        state_r <= WAIT_DONE;
                    end else begin
                        state_r <= WAIT_BUSY;
                    end
                end
                WAIT_DONE: begin
                    if (timeout_s) begin
                        gnt_r   <= '0;
                        ptr_r   <= win_r;
                        state_r <= IDLE;
                    end else if (!ser_busy) begin
                        done_r  <= gnt_r;
                        gnt_r   <= '0;
                        ptr_r   <= win_r;
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_DONE;
                    end
                end
                default: begin
                    gnt_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign gnt      = gnt_r;
    assign done     = done_r;
    assign ser_data = ser_data_r;
    assign ser_load = ser_load_r;

endmodule

// File: tb/tb_ptosda_arbiter.sv
// Directed self-checking bench for ptosda_arbiter (N=4); busy is driven directly by the sequence.
module tb_ptosda_arbiter;

    logic        sclk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  ser_data;
    logic        ser_load;
    logic        ser_busy;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] nib3 [4];

    ptosda_arbiter #(.N(4), .TIMEOUT(64), .TW(8)) dut (
        .sclk     (sclk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .ser_data (ser_data),
        .ser_load (ser_load),
        .ser_busy (ser_busy),
        .err      (err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic tick();
        @(negedge sclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int w);
        logic [3:0] v;
        v = 4'b0001 << w;
        return v;
    endfunction

    // Entered at a negedge with the DUT in IDLE and req already driven; returns at the done cycle.
    task automatic xfer(input string tag, input int w, input logic [3:0] data, input int dly,
                        input int len, input logic [3:0] req_after, input logic [15:0] rd_after);
        tick();
        chk({tag, ".gnt"}, gnt, oh(w));
        chk({tag, ".data"}, ser_data, data);
        chk({tag, ".load0"}, ser_load, 1'b0);
        chk({tag, ".done0"}, done, 4'b0000);
        chk({tag, ".err0"}, err, 1'b0);
        req      = req_after;
        req_data = rd_after;
        if (dly == 0) ser_busy = 1'b1;
        tick();
        chk({tag, ".load1"}, ser_load, 1'b1);
        chk({tag, ".gnt_ld"}, gnt, oh(w));
        if (dly > 0) begin
            for (int c = 1; c < dly; c++) begin
                tick();
                chk({tag, ".load_pre"}, ser_load, 1'b0);
            end
            ser_busy = 1'b1;
        end
        for (int c = 0; c < len; c++) begin
            tick();
            chk({tag, ".gnt_hold"}, gnt, oh(w));
            chk({tag, ".data_hold"}, ser_data, data);
            chk({tag, ".load_busy"}, ser_load, 1'b0);
            chk({tag, ".done_busy"}, done, 4'b0000);
            chk({tag, ".err_busy"}, err, 1'b0);
        end
        ser_busy = 1'b0;
        tick();
        chk({tag, ".done"}, done, oh(w));
        chk({tag, ".gnt_off"}, gnt, 4'b0000);
        chk({tag, ".err_done"}, err, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        req_data = 16'h0000;
        ser_busy = 1'b0;
        nib3[0] = 4'hE;
        nib3[1] = 4'h3;
        nib3[2] = 4'hC;
        nib3[3] = 4'h8;
        tick();
        tick();
        chk("rst.gnt", gnt, 4'b0000);
        chk("rst.done", done, 4'b0000);
        chk("rst.data", ser_data, 4'h0);
        chk("rst.load", ser_load, 1'b0);
        chk("rst.err", err, 1'b0);
        rst = 1'b0;

        // Single requester, late busy, data change after grant ignored
        req      = 4'b0100;
        req_data = 16'h0A00;
        xfer("t2", 2, 4'hA, 3, 10, 4'b0000, 16'hFFFF);

        // Request dropped right after grant still completes
        req      = 4'b0010;
        req_data = 16'h0070;
        xfer("t4", 1, 4'h7, 1, 3, 4'b0000, 16'h0070);

        // Busy already high during LOAD
        req      = 4'b1000;
        req_data = 16'h5000;
        xfer("t5", 3, 4'h5, 0, 2, 4'b0000, 16'h5000);

        // All requesting: round-robin order with one IDLE cycle between transfers
        req      = 4'b1111;
        req_data = 16'h8C3E;
        for (int k = 0; k < 8; k++) begin
            xfer("t3", k % 4, nib3[k % 4], 1, 2, 4'b1111, 16'h8C3E);
        end
        req = 4'b0000;

`ifdef ARB_TIMEOUT_EN
        req      = 4'b0001;
        req_data = 16'h0069;
        tick();
        chk("t6.gnt", gnt, 4'b0001);
        ser_busy = 1'b1;
        req      = 4'b0010;
        tick();
        chk("t6.load", ser_load, 1'b1);
        repeat (63) tick();
        chk("t6.err_early", err, 1'b0);
        chk("t6.gnt_early", gnt, 4'b0001);
        tick();
        chk("t6.err", err, 1'b1);
        chk("t6.gnt_abort", gnt, 4'b0000);
        chk("t6.no_done", done, 4'b0000);
        ser_busy = 1'b0;
        xfer("t6b", 1, 4'h6, 1, 2, 4'b0000, 16'h0069);
`else
        // Busy stuck for a long time: no abort, sequencer keeps waiting
        req      = 4'b0001;
        req_data = 16'h0009;
        xfer("t6", 0, 4'h9, 0, 100, 4'b0000, 16'h0009);
`endif

        // Asynchronous reset in the middle of WAIT_DONE
        req      = 4'b0100;
        req_data = 16'h0C00;
        tick();
        ser_busy = 1'b1;
        req      = 4'b0000;
        tick();
        tick();
        chk("t1.gnt_pre", gnt, 4'b0100);
        #2 rst = 1'b1;
        #1;
        chk("t1.gnt", gnt, 4'b0000);
        chk("t1.done", done, 4'b0000);
        chk("t1.data", ser_data, 4'h0);
        chk("t1.load", ser_load, 1'b0);
        chk("t1.err", err, 1'b0);
        ser_busy = 1'b0;
        tick();
        rst      = 1'b0;
        req      = 4'b1111;
        req_data = 16'h8C3E;
        tick();
        chk("t1.first_gnt", gnt, 4'b0001);
        chk("t1.first_data", ser_data, 4'hE);
        req = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
